voice_mixer: RTL
================

// Module: voice_mixer
// PURPOSE
//   Per-sample frame sequencer and mixer downstream of multi_voice. On each sample tick it
//   time-multiplexes the shared voice generator over all voices: start, wait for ready, capture.
//   Each captured 10-bit wave is re-centred to signed, scaled by a per-voice volume and summed.
//   The result is one signed mixed sample with a one-cycle valid strobe, feeding filter/output stages.
// PARAMETERS
//   NUM_VOICES  3   voices sequenced per frame (1..4; index fits mv_act_voice_o)
//   VOL_W       4   per-voice volume width, unsigned, 0 = mute
// PORTS
//   clk_i            in   1                 system clock, 50 MHz
//   rst_ni           in   1                 asynchronous reset, active low
//   sample_tick_i    in   1                 one-cycle frame request, 50 kHz
//   freq_word_i      in   NUM_VOICES*16     packed per-voice frequency words, voice 0 in LSBs
//   pw_word_i        in   NUM_VOICES*12     packed per-voice pulse widths
//   wave_sel_i       in   NUM_VOICES*4      packed per-voice one-hot waveform selects
//   vol_i            in   NUM_VOICES*VOL_W  packed per-voice volumes
//   mv_start_o       out  1                 start pulse to multi_voice
//   mv_act_voice_o   out  2                 active voice index to multi_voice
//   mv_freq_word_o   out  16                frequency word for the active voice
//   mv_pw_word_o     out  12                pulse width for the active voice
//   mv_wave_sel_o    out  4                 waveform select for the active voice
//   mv_ready_i       in   1                 multi_voice done strobe
//   mv_wave_i        in   10                multi_voice wave output, unsigned
//   sample_o         out  16                mixed sample, signed two's complement
//   sample_valid_o   out  1                 one-cycle strobe, sample_o updated
//   overrun_o        out  1                 sticky: tick arrived while a frame was in progress
// BEHAVIOUR
//   Reset (async, rst_ni low): state IDLE, voice index 0, accumulator 0.
//     All outputs are 0, including mv_*, sample_o, sample_valid_o and overrun_o.
//     Reset mid-frame abandons the frame; no sample_valid_o is issued for it.
//   FSM states: IDLE, START, WAIT.
//   IDLE
//     sample_tick_i=1: snapshot all config inputs into shadow registers, clear accumulator,
//     set index to 0, go to START.
//     Config input changes after the snapshot have no effect until the next frame.
//   START
//     mv_start_o=1 for exactly this cycle; go to WAIT.
//   mv_act_voice_o, mv_freq_word_o, mv_pw_word_o, mv_wave_sel_o
//     Registered, driven from the shadow for the current index.
//     Stable from START until the cycle after mv_ready_i. 0 while IDLE.
//   WAIT
//     Hold until mv_ready_i=1. In that cycle capture mv_wave_i.
//     Scaled term: s = ($signed({1'b0,mv_wave_i}) - 512) * vol, range -7680..7665 for VOL_W=4.
//     Accumulate: acc += s (18-bit internal, sign-extended).
//     If index < NUM_VOICES-1: index++, go to START.
//     Else: next cycle sample_o <= acc+s, saturated to 16-bit signed; sample_valid_o=1 for
//     one cycle; go to IDLE.
//     Defaults cannot reach saturation (max |sum| = 23040); saturation is still required.
//   Latency: with multi_voice's 3-cycle start-to-ready, each voice takes 4 cycles.
//     NUM_VOICES=3: tick in cycle 0, START in cycles 1/5/9, sample_valid_o high in cycle 13.
//   sample_o holds its value between strobes.
//   sample_tick_i while not IDLE: ignored (frame continues unchanged), overrun_o <= 1.
//     overrun_o stays 1 until reset.
//   Tick in the same cycle sample_valid_o is high: FSM is already IDLE; the tick is accepted,
//     no overrun.
//   mv_ready_i outside WAIT: ignored.
//   vol=0: voice still sequenced (phase and LFSR advance) but contributes 0.
// TESTING
//   1. Reset, tick, all vol=0 -> 3 mv_start_o pulses at cycles 1/5/9, act_voice 0/1/2;
//      sample_valid_o at cycle 13 with sample_o=0.
//   2. Responder returns wave 1023 for all voices, vol=15 -> sample_o = 3*511*15 = 22995 (0x59D3).
//   3. Waves 0/512/1023, vols 15/7/1 -> sample_o = -7680+0+511 = -7169.
//   4. Tick at cycle 6 of a frame -> frame completes unchanged, overrun_o=1 until reset.
//      Tick on the valid cycle -> new frame, overrun unchanged.
//   5. Change freq_word_i for voice 2 at cycle 3 -> mv_freq_word_o for voice 2 shows the
//      snapshot value. Delay mv_ready_i by 10 cycles -> outputs held stable, sum correct.
//   6. rst_ni low at cycle 7 -> all outputs 0 immediately, no valid strobe.
//      Next tick -> clean frame with correct sum.
//   Bench also runs against real multi_voice with saw waves; checks the frame count equals
//   the accepted tick count.

Source files
------------

// File: rtl/voice_mixer.sv
// voice_mixer: per-sample frame sequencer and mixer in front of the filter stages.
// On each sample tick the shared multi_voice generator is run once per voice
// (start, wait for ready, capture). Each captured wave is re-centred to signed,
// scaled by that voice's volume and accumulated; the saturated sum is presented
// on sample_o with a one-cycle sample_valid_o strobe.
//
// Handshake with multi_voice: mv_start_o is a one-cycle request, and the mv_*
// config outputs are valid from that cycle up to and including the cycle where
// mv_ready_i is seen. mv_ready_i is a one-cycle done strobe qualifying
// mv_wave_i, and it is only honoured while waiting for the active voice.
module voice_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int VOL_W      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        sample_tick_i,
    input  logic [NUM_VOICES*16-1:0]    freq_word_i,
    input  logic [NUM_VOICES*12-1:0]    pw_word_i,
    input  logic [NUM_VOICES*4-1:0]     wave_sel_i,
    input  logic [NUM_VOICES*VOL_W-1:0] vol_i,
    output logic                        mv_start_o,
    output logic [1:0]                  mv_act_voice_o,
    output logic [15:0]                 mv_freq_word_o,
    output logic [11:0]                 mv_pw_word_o,
    output logic [3:0]                  mv_wave_sel_o,
    input  logic                        mv_ready_i,
    input  logic [9:0]                  mv_wave_i,
    output logic [15:0]                 sample_o,
    output logic                        sample_valid_o,
    output logic                        overrun_o
);

    // Scaled term: 11-bit signed wave times (VOL_W+1)-bit signed volume.
    localparam int PROD_W = VOL_W + 12;
    // Two guard bits cover up to four voices; never narrower than 18 bits.
    localparam int ACC_W  = (PROD_W + 2 > 18) ? PROD_W + 2 : 18;
    localparam logic [1:0] LAST_IDX = 2'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    idx_q, idx_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [NUM_VOICES*16-1:0]      freq_sh_q, freq_sh_d;
    logic [NUM_VOICES*12-1:0]      pw_sh_q, pw_sh_d;
    logic [NUM_VOICES*4-1:0]       sel_sh_q, sel_sh_d;
    logic [NUM_VOICES*VOL_W-1:0]   vol_sh_q, vol_sh_d;
    logic [1:0]                    act_q, act_d;
    logic [15:0]                   freq_q, freq_d;
    logic [11:0]                   pw_q, pw_d;
    logic [3:0]                    sel_q, sel_d;
    logic [15:0]                   sample_q, sample_d;
    logic                          valid_q, valid_d;
    logic                          overrun_q, overrun_d;

    logic [1:0]                    nxt_idx;
    logic [VOL_W-1:0]              vol_cur;
    logic signed [10:0]            centred;
    logic signed [VOL_W:0]         vol_s;
    logic signed [PROD_W-1:0]      term;
    logic signed [ACC_W-1:0]       sum;
    logic [15:0]                   sum_sat;

    // Datapath: re-centre the captured wave, scale by volume, add to the running sum.
    always_comb begin
        nxt_idx = idx_q + 2'd1;
        vol_cur = vol_sh_q[idx_q*VOL_W +: VOL_W];
        centred = $signed({1'b0, mv_wave_i}) - 11'sd512;
        vol_s   = $signed({1'b0, vol_cur});
        term    = centred * vol_s;
        sum     = acc_q + {{(ACC_W-PROD_W){term[PROD_W-1]}}, term};
        // Saturate when the bits above bit 15 are not a pure sign extension.
        if (!sum[ACC_W-1] && (|sum[ACC_W-2:15])) begin
            sum_sat = 16'h7FFF;
        end else if (sum[ACC_W-1] && !(&sum[ACC_W-2:15])) begin
            sum_sat = 16'h8000;
        end else begin
            sum_sat = sum[15:0];
        end
    end

    // Next-state logic: frame sequencing, snapshot, voice advance, final sample.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        freq_sh_d = freq_sh_q;
        pw_sh_d   = pw_sh_q;
        sel_sh_d  = sel_sh_q;
        vol_sh_d  = vol_sh_q;
        act_d     = act_q;
        freq_d    = freq_q;
        pw_d      = pw_q;
        sel_d     = sel_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_tick_i) begin
                    freq_sh_d = freq_word_i;
                    pw_sh_d   = pw_word_i;
                    sel_sh_d  = wave_sel_i;
                    vol_sh_d  = vol_i;
                    acc_d     = '0;
                    idx_d     = 2'd0;
                    act_d     = 2'd0;
                    freq_d    = freq_word_i[15:0];
                    pw_d      = pw_word_i[11:0];
                    sel_d     = wave_sel_i[3:0];
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mv_ready_i) begin
                    acc_d = sum;
                    if (idx_q != LAST_IDX) begin
                        idx_d   = nxt_idx;
                        act_d   = nxt_idx;
                        freq_d  = freq_sh_q[nxt_idx*16 +: 16];
                        pw_d    = pw_sh_q[nxt_idx*12 +: 12];
                        sel_d   = sel_sh_q[nxt_idx*4 +: 4];
                        state_d = ST_START;
                    end else begin
                        sample_d = sum_sat;
                        valid_d  = 1'b1;
                        act_d    = 2'd0;
                        freq_d   = 16'd0;
                        pw_d     = 12'd0;
                        sel_d    = 4'd0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick that arrives mid-frame is dropped but remembered until reset.
        if (sample_tick_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            acc_q     <= '0;
            freq_sh_q <= '0;
            pw_sh_q   <= '0;
            sel_sh_q  <= '0;
            vol_sh_q  <= '0;
            act_q     <= 2'd0;
            freq_q    <= 16'd0;
            pw_q      <= 12'd0;
            sel_q     <= 4'd0;
            sample_q  <= 16'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            freq_sh_q <= freq_sh_d;
            pw_sh_q   <= pw_sh_d;
            sel_sh_q  <= sel_sh_d;
            vol_sh_q  <= vol_sh_d;
            act_q     <= act_d;
            freq_q    <= freq_d;
            pw_q      <= pw_d;
            sel_q     <= sel_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs: start pulse decoded from state, everything else straight from registers.
    always_comb begin
        mv_start_o     = (state_q == ST_START);
        mv_act_voice_o = act_q;
        mv_freq_word_o = freq_q;
        mv_pw_word_o   = pw_q;
        mv_wave_sel_o  = sel_q;
        sample_o       = sample_q;
        sample_valid_o = valid_q;
        overrun_o      = overrun_q;
    end

endmodule
